test_vector_player: RTL and testbench
=====================================

TEST_VECTOR_PLAYER -- requirements
Module: test_vector_player

Interface
REQ-001 Parameter IN_W, default 8, stimulus width driven to the DUT.
REQ-002 Parameter OUT_W, default 8, response width returned by the DUT.
REQ-003 Parameter DEPTH, default 16, vector memory entries; AW = clog2(DEPTH).
REQ-004 Parameter TIMEOUT, default 15, max WAIT cycles per vector.
REQ-005 clk  in  1  sole clock, all logic on posedge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 load_en  in  1  write one vector entry this cycle.
REQ-008 load_addr  in  AW  entry index.
REQ-009 load_stim  in  IN_W  stimulus for entry.
REQ-010 load_exp  in  OUT_W  expected response for entry.
REQ-011 start  in  1  begin a run (level sampled in IDLE).
REQ-012 num_vec  in  AW+1  vectors to run, sampled on accepted start.
REQ-013 stim  out  IN_W  stimulus to DUT.
REQ-014 stim_valid  out  1  one-cycle strobe: stim is new.
REQ-015 resp_valid  in  1  DUT response strobe.
REQ-016 resp  in  OUT_W  DUT response data.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  sticky run-complete flag.
REQ-019 pass_cnt, fail_cnt  out  AW+1 each  vectors matched / mismatched.
REQ-020 first_fail_idx  out  AW  index of first failing vector; first_fail_seen  out  1  valid flag.
REQ-021 timeout_err  out  1  sticky, run aborted on timeout.
REQ-022 quit  out  1  one-cycle pulse at end of run (simulation-finish request).

Function
REQ-023 States IDLE, ISSUE, WAIT, CHECK, FINISH; one state per cycle except WAIT.
REQ-024 load_en writes mem[load_addr] only in IDLE; ignored when busy; start and load_en together: write occurs, then start accepted same cycle using old contents only for entries not written.
REQ-025 IDLE + start: clear pass_cnt, fail_cnt, first_fail_seen, first_fail_idx, timeout_err, done; idx=0; latch n=min(num_vec, DEPTH); n==0 -> FINISH, else ISSUE.
REQ-026 start while busy is ignored.
REQ-027 ISSUE: stim=mem[idx].stim, stim_valid=1 for exactly this cycle; timer=0; -> WAIT.
REQ-028 stim holds its value from ISSUE until next ISSUE or reset.
REQ-029 resp_valid sampled only in WAIT; strobes in other states are discarded.
REQ-030 WAIT + resp_valid: capture resp -> CHECK; otherwise timer+1.
REQ-031 WAIT with timer==TIMEOUT and no resp_valid: fail_cnt+1, timeout_err=1, record first fail if none, -> FINISH (remaining vectors not run).
REQ-032 CHECK: resp==mem[idx].exp -> pass_cnt+1; else fail_cnt+1, and if !first_fail_seen set first_fail_idx=idx, first_fail_seen=1.
REQ-033 CHECK: idx==n-1 -> FINISH, else idx+1 -> ISSUE.
REQ-034 Per-vector latency = 2 + WAIT cycles; minimum 3 cycles (response on first WAIT cycle).
REQ-035 FINISH: done=1 (held until next accepted start or reset), quit=1 this cycle only, -> IDLE.
REQ-036 pass_cnt+fail_cnt never exceeds n; no counter wraps.

Reset
REQ-037 rst forces IDLE, in any state including mid-run; stim=0, stim_valid=0, busy=0, done=0, quit=0, counters=0, first_fail_idx=0, first_fail_seen=0, timeout_err=0.
REQ-038 Vector memory is not reset; contents survive rst.

Verification
REQ-039 Load 4 vectors exp=stim, DUT echoes resp one cycle after stim_valid, num_vec=4 -> pass_cnt=4, fail_cnt=0, done=1, single quit pulse, 4 stim_valid strobes.
REQ-040 Same with entry 2 exp corrupted (0xAA vs 0x55) -> pass_cnt=3, fail_cnt=1, first_fail_idx=2, first_fail_seen=1.
REQ-041 DUT silent on vector 1 -> after 16 WAIT cycles timeout_err=1, fail_cnt=1, pass_cnt=1, first_fail_idx=1, quit pulses.
REQ-042 num_vec=0 -> FINISH next cycle, no stim_valid, done=1, counters 0; num_vec=20 -> exactly 16 vectors run.
REQ-043 rst asserted in WAIT of vector 3 -> next cycle IDLE, all outputs 0; memory unchanged on rerun (pass_cnt=4).
REQ-044 start and load_en pulsed while busy -> no restart, memory unchanged; spurious resp_valid in ISSUE/CHECK ignored.

Source files
------------

// File: rtl/test_vector_player.sv
// test_vector_player: replays stored stimulus vectors into a device under test,
// waits for each response with a bounded timeout, and tallies matches against
// the stored expected responses. Raises done/quit when the run completes.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | memory loadable, waiting for start
//   S_ISSUE  | present mem[idx].stim with a one-cycle stim_valid strobe
//   S_WAIT   | wait for resp_valid, abort the run after TIMEOUT+1 cycles
//   S_CHECK  | compare captured response against mem[idx].exp
//   S_FINISH | run complete: done set, one-cycle quit pulse
module test_vector_player #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [IN_W-1:0]  load_stim,
    input  logic [OUT_W-1:0] load_exp,
    input  logic             start,
    input  logic [AW:0]      num_vec,
    output logic [IN_W-1:0]  stim,
    output logic             stim_valid,
    input  logic             resp_valid,
    input  logic [OUT_W-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      pass_cnt,
    output logic [AW:0]      fail_cnt,
    output logic [AW-1:0]    first_fail_idx,
    output logic             first_fail_seen,
    output logic             timeout_err,
    output logic             quit
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_W = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t state_q, state_d;

    logic [IN_W-1:0]  mem_stim [DEPTH];
    logic [OUT_W-1:0] mem_exp  [DEPTH];

    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      n_q, n_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [OUT_W-1:0] resp_q, resp_d;
    logic [IN_W-1:0]  stim_q, stim_d;
    logic [AW:0]      pass_q, pass_d;
    logic [AW:0]      fail_q, fail_d;
    logic [AW-1:0]    ffidx_q, ffidx_d;
    logic             ffseen_q, ffseen_d;
    logic             tmo_q, tmo_d;
    logic             done_q, done_d;
    logic [AW:0]      n_eff;

    // Vector memory: writable only while idle, never reset so vectors survive rst.
    always_ff @(posedge clk) begin
        if (load_en && (state_q == S_IDLE)) begin
            mem_stim[load_addr] <= load_stim;
            mem_exp[load_addr]  <= load_exp;
        end
    end

    assign n_eff = (num_vec > DEPTH_W) ? DEPTH_W : num_vec;

    // Next-state and datapath updates for the sequencing FSM.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        timer_d  = timer_q;
        resp_d   = resp_q;
        stim_d   = stim_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        ffidx_d  = ffidx_q;
        ffseen_d = ffseen_q;
        tmo_d    = tmo_q;
        done_d   = done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pass_d   = '0;
                    fail_d   = '0;
                    ffidx_d  = '0;
                    ffseen_d = 1'b0;
                    tmo_d    = 1'b0;
                    done_d   = 1'b0;
                    idx_d    = '0;
                    n_d      = n_eff;
                    state_d  = (n_eff == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                stim_d  = mem_stim[idx_q];
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (resp_valid) begin
                    resp_d  = resp;
                    state_d = S_CHECK;
                end else if (timer_q == TIMEOUT_W) begin
                    fail_d = fail_q + 1'b1;
                    tmo_d  = 1'b1;
                    if (!ffseen_q) begin
                        ffseen_d = 1'b1;
                        ffidx_d  = idx_q;
                    end
                    state_d = S_FINISH;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (resp_q == mem_exp[idx_q]) begin
                    pass_d = pass_q + 1'b1;
                end else begin
                    fail_d = fail_q + 1'b1;
                    if (!ffseen_q) begin
                        ffseen_d = 1'b1;
                        ffidx_d  = idx_q;
                    end
                end
                if ({1'b0, idx_q} == (n_q - 1'b1)) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // done rises together with the quit pulse so a harness sees both at once.
        if (state_d == S_FINISH) begin
            done_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            n_q      <= '0;
            timer_q  <= '0;
            resp_q   <= '0;
            stim_q   <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            ffidx_q  <= '0;
            ffseen_q <= 1'b0;
            tmo_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            timer_q  <= timer_d;
            resp_q   <= resp_d;
            stim_q   <= stim_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            ffidx_q  <= ffidx_d;
            ffseen_q <= ffseen_d;
            tmo_q    <= tmo_d;
            done_q   <= done_d;
        end
    end

    // During ISSUE the stimulus comes straight from memory so it lines up with
    // stim_valid; afterwards the registered copy holds it until the next ISSUE.
    assign stim            = (state_q == S_ISSUE) ? mem_stim[idx_q] : stim_q;
    assign stim_valid      = (state_q == S_ISSUE);
    assign busy            = (state_q != S_IDLE);
    assign quit            = (state_q == S_FINISH);
    assign done            = done_q;
    assign pass_cnt        = pass_q;
    assign fail_cnt        = fail_q;
    assign first_fail_idx  = ffidx_q;
    assign first_fail_seen = ffseen_q;
    assign timeout_err     = tmo_q;

endmodule

// File: tb/tb_test_vector_player.sv
// Bench for test_vector_player: scenario table with hand-derived results,
// a few directed multi-cycle sequences, and randomized runs scored against
// a cycle-level arithmetic model of the run.
module tb_test_vector_player;

    localparam int IN_W    = 8;
    localparam int OUT_W   = 8;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 15;
    localparam int SILENT  = 99;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [IN_W-1:0]  load_stim;
    logic [OUT_W-1:0] load_exp;
    logic             start;
    logic [AW:0]      num_vec;
    logic [IN_W-1:0]  stim;
    logic             stim_valid;
    logic             resp_valid = 1'b0;
    logic [OUT_W-1:0] resp = '0;
    logic             busy;
    logic             done;
    logic [AW:0]      pass_cnt;
    logic [AW:0]      fail_cnt;
    logic [AW-1:0]    first_fail_idx;
    logic             first_fail_seen;
    logic             timeout_err;
    logic             quit;

    test_vector_player #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_stim(load_stim), .load_exp(load_exp), .start(start),
        .num_vec(num_vec), .stim(stim), .stim_valid(stim_valid),
        .resp_valid(resp_valid), .resp(resp), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_seen(first_fail_seen),
        .timeout_err(timeout_err), .quit(quit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: memory image, per-vector responder behaviour.
    logic [7:0] m_stim [DEPTH];
    logic [7:0] m_exp  [DEPTH];
    int         dly    [DEPTH];
    logic [7:0] xr     [DEPTH];
    bit         from_exp = 1'b0;
    bit         spur_en  = 1'b0;
    int         vnum     = 0;
    int         pend     = -1;
    logic [7:0] pend_data;
    logic [7:0] last_stim = '0;
    bit         extend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Responder acting as the device under test; all activity on negedge.
    always @(negedge clk) begin
        resp_valid = 1'b0;
        resp       = '0;
        if (rst) begin
            last_stim = '0;
            pend      = -1;
            extend    = 1'b0;
        end else begin
            if (extend) begin
                resp_valid = 1'b1;
                resp       = 8'hEE;
                extend     = 1'b0;
            end
            if (pend > 0) begin
                pend--;
            end else if (pend == 0) begin
                resp_valid = 1'b1;
                resp       = pend_data;
                pend       = -1;
                if (spur_en) extend = 1'b1;
            end
            if (stim_valid) begin
                if (vnum < DEPTH) begin
                    chk("stim_value", stim, m_stim[vnum]);
                    if (dly[vnum] < SILENT) begin
                        pend      = dly[vnum] - 1;
                        pend_data = (from_exp ? m_exp[vnum] : stim) ^ xr[vnum];
                    end
                end
                if (spur_en) begin
                    resp_valid = 1'b1;
                    resp       = 8'hEE;
                end
                last_stim = stim;
                vnum++;
            end else begin
                chk("stim_hold", stim, last_stim);
            end
        end
    end

    task automatic load(input int a, input logic [7:0] s, input logic [7:0] e);
        load_en   = 1'b1;
        load_addr = a[AW-1:0];
        load_stim = s;
        load_exp  = e;
        m_stim[a] = s;
        m_exp[a]  = e;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic load_base();
        for (int i = 0; i < DEPTH; i++) load(i, 8'(8'h53 + i), 8'(8'h53 + i));
    endtask

    task automatic plain_responder();
        for (int i = 0; i < DEPTH; i++) begin
            dly[i] = 1;
            xr[i]  = '0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_quit"}, quit, 0);
        chk({tag, "_stim"}, stim, 0);
        chk({tag, "_stim_valid"}, stim_valid, 0);
        chk({tag, "_pass"}, pass_cnt, 0);
        chk({tag, "_fail"}, fail_cnt, 0);
        chk({tag, "_ffidx"}, first_fail_idx, 0);
        chk({tag, "_ffseen"}, first_fail_seen, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
    endtask

    // Starts a run at a negedge and returns the cycle (1 = first cycle after
    // the start edge) in which quit was seen.
    task automatic run_vec(input int nv, input bit inj_busy, input bit ld_same, output int qcyc);
        int  quits = 0;
        bit  got   = 1'b0;
        qcyc    = 0;
        vnum    = 0;
        start   = 1'b1;
        num_vec = 5'(nv);
        if (ld_same) begin
            load_en   = 1'b1;
            load_addr = '0;
            load_stim = m_stim[0];
            load_exp  = m_exp[0];
        end
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            start   = 1'b0;
            load_en = 1'b0;
            if (i == 1) chk("busy_after_start", busy, 1);
            if (inj_busy && i == 5) begin
                start     = 1'b1;
                num_vec   = 5'd2;
                load_en   = 1'b1;
                load_addr = '0;
                load_stim = ~m_stim[0];
                load_exp  = ~m_exp[0];
            end
            if (quit) begin
                quits++;
                if (!got) begin
                    got  = 1'b1;
                    qcyc = i;
                end
            end
            if (got && i >= qcyc + 3) break;
        end
        start   = 1'b0;
        load_en = 1'b0;
        chk("quit_seen", got, 1);
        chk("quit_pulses", quits, 1);
        chk("busy_after_run", busy, 0);
        chk("done_after_run", done, 1);
    endtask

    typedef struct {
        int nv;
        int bad_exp;
        int silent;
        int pass;
        int fail;
        int ffidx;
        int ffseen;
        int tmo;
        int strobes;
        int cyc;
    } row_t;

    row_t rows [6];

    initial begin
        int qc;
        rst       = 1'b1;
        start     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_stim = '0;
        load_exp  = '0;
        num_vec   = '0;
        plain_responder();

        rows[0] = '{4,  -1, -1,  4, 0,  0, 0, 0,  4, 13};
        rows[1] = '{4,   2, -1,  3, 1,  2, 1, 0,  4, 13};
        rows[2] = '{4,  -1,  1,  1, 1,  1, 1, 1,  2, 21};
        rows[3] = '{0,  -1, -1,  0, 0,  0, 0, 0,  0,  1};
        rows[4] = '{20, -1, -1, 16, 0,  0, 0, 0, 16, 49};
        rows[5] = '{16, -1, 15, 15, 1, 15, 1, 1, 16, 63};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Scenario table, responder echoes the stimulus.
        from_exp = 1'b0;
        for (int r = 0; r < 6; r++) begin
            load_base();
            if (rows[r].bad_exp >= 0) load(rows[r].bad_exp, m_stim[rows[r].bad_exp], ~m_stim[rows[r].bad_exp]);
            plain_responder();
            if (rows[r].silent >= 0) dly[rows[r].silent] = SILENT;
            run_vec(rows[r].nv, 1'b0, 1'b0, qc);
            chk("row_pass", pass_cnt, rows[r].pass);
            chk("row_fail", fail_cnt, rows[r].fail);
            chk("row_ffidx", first_fail_idx, rows[r].ffidx);
            chk("row_ffseen", first_fail_seen, rows[r].ffseen);
            chk("row_tmo", timeout_err, rows[r].tmo);
            chk("row_strobes", vnum, rows[r].strobes);
            chk("row_cycles", qc, rows[r].cyc);
        end

        // Reset while waiting on vector 3, then rerun from surviving memory.
        load_base();
        plain_responder();
        dly[3]  = SILENT;
        vnum    = 0;
        start   = 1'b1;
        num_vec = 5'd4;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (vnum >= 4) break;
        end
        chk("reached_vec3", vnum, 4);
        @(negedge clk);
        chk("busy_in_wait", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dly[3] = 1;
        run_vec(4, 1'b0, 1'b0, qc);
        chk("rerun_pass", pass_cnt, 4);
        chk("rerun_fail", fail_cnt, 0);
        chk("rerun_cycles", qc, 13);

        // start/load while busy, spurious response strobes in ISSUE and CHECK.
        spur_en = 1'b1;
        run_vec(4, 1'b1, 1'b0, qc);
        chk("busy_inj_pass", pass_cnt, 4);
        chk("busy_inj_fail", fail_cnt, 0);
        chk("busy_inj_strobes", vnum, 4);
        chk("busy_inj_cycles", qc, 13);
        run_vec(4, 1'b0, 1'b0, qc);
        chk("mem_kept_pass", pass_cnt, 4);
        chk("mem_kept_fail", fail_cnt, 0);
        spur_en = 1'b0;

        // load_en and start in the same cycle: new entry 0 is used.
        m_stim[0] = 8'h9C;
        m_exp[0]  = 8'h9C;
        run_vec(4, 1'b0, 1'b1, qc);
        chk("same_cycle_pass", pass_cnt, 4);
        chk("same_cycle_fail", fail_cnt, 0);
        chk("same_cycle_cycles", qc, 13);

        // Randomized runs against the arithmetic model.
        from_exp = 1'b1;
        for (int it = 0; it < 14; it++) begin
            int nv, n, ep, ef, ei, es, et, ec, est;
            int nl;
            nl = $urandom_range(0, 16);
            for (int j = 0; j < nl; j++)
                load($urandom_range(0, DEPTH - 1), 8'($urandom), 8'($urandom));
            for (int v = 0; v < DEPTH; v++) begin
                if ($urandom_range(0, 19) == 0)      dly[v] = SILENT;
                else if ($urandom_range(0, 9) == 0)  dly[v] = $urandom_range(15, 17);
                else                                 dly[v] = $urandom_range(1, 4);
                xr[v] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            end
            spur_en = ($urandom_range(0, 1) == 1);
            nv = $urandom_range(0, 20);

            n  = (nv > DEPTH) ? DEPTH : nv;
            ep = 0; ef = 0; ei = 0; es = 0; et = 0; ec = 1; est = 0;
            for (int v = 0; v < n; v++) begin
                est++;
                if (dly[v] > TIMEOUT + 1) begin
                    ef++;
                    et = 1;
                    if (es == 0) begin es = 1; ei = v; end
                    ec += 2 + TIMEOUT;
                    break;
                end
                ec += 2 + dly[v];
                if (xr[v] == 8'h00) ep++;
                else begin
                    ef++;
                    if (es == 0) begin es = 1; ei = v; end
                end
            end

            run_vec(nv, 1'b0, 1'b0, qc);
            chk("rand_pass", pass_cnt, ep);
            chk("rand_fail", fail_cnt, ef);
            chk("rand_ffidx", first_fail_idx, ei);
            chk("rand_ffseen", first_fail_seen, es);
            chk("rand_tmo", timeout_err, et);
            chk("rand_strobes", vnum, est);
            chk("rand_cycles", qc, ec);
        end
        spur_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
